// File: rtl/ultrasonic_ranger_if.sv
// Signal bundle between the ultrasonic ranger (slave) and its sensor/consumer side (master).
interface ultrasonic_ranger_if;
    logic       Enable;
    logic       Echo;
    logic       Trig;
    logic [7:0] Distance;
    logic       Valid;
    logic       Timeout;

    modport master (output Enable, output Echo,
                    input  Trig, input Distance, input Valid, input Timeout);
    modport slave  (input  Enable, input Echo,
                    output Trig, output Distance, output Valid, output Timeout);
endinterface

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo timing in whole cm, timeout, one-cycle valid strobe.
// Optional RANGER_AVG4_EN: Distance becomes the rounded mean of the last four results.
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES    = 500,
    parameter int CYCLES_PER_CM  = 2900,
    parameter int TIMEOUT_CYCLES = 1250000,
    parameter int PERIOD_CYCLES  = 3000000
) (
    input logic                CLK,
    input logic                RST,
    ultrasonic_ranger_if.slave bus
);
    // state     | meaning
    // IDLE      | disabled, waiting for Enable with period expired
    // TRIG      | trigger pulse window, period counter restarted
    // WAIT_RISE | waiting for echo rising edge, timeout running
    // MEASURE   | counting echo-high cycles into cm, timeout running
    // DONE      | result latched, Valid high for one cycle
    // HOLDOFF   | waiting for the end of the measurement period

    localparam int TMR_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
    localparam int TW      = $clog2(TMR_MAX);
    localparam int PW      = $clog2(PERIOD_CYCLES);
    localparam int SW      = $clog2(CYCLES_PER_CM);

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_DONE, S_HOLDOFF
    } state_e;

    state_e         state_q, state_d;
    logic           echo_s1_q, echo_s2_q, echo_dly_q;
    logic           rise_q, fall_q;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [PW-1:0]  per_q, per_d;
    logic [SW-1:0]  sub_q, sub_d;
    logic [7:0]     cm_q, cm_d;
    logic [7:0]     dist_q, dist_d;
    logic           tout_q, tout_d;
    logic           trig_q, trig_d;
    logic           valid, latch, res_tout, trig_entry;
    logic [7:0]     res;
    logic           tmr_zero, per_zero;

    assign tmr_zero = (tmr_q == '0);
    assign per_zero = (per_q == '0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (bus.Enable && per_zero) state_d = S_TRIG;
            S_TRIG:      if (tmr_zero) state_d = S_WAIT_RISE;
            S_WAIT_RISE: begin
                if (tmr_zero)    state_d = S_DONE;
                else if (rise_q) state_d = S_MEASURE;
            end
            // a falling edge in the expiry cycle still yields a real result
            S_MEASURE:   if (fall_q || tmr_zero) state_d = S_DONE;
            S_DONE:      state_d = S_HOLDOFF;
            S_HOLDOFF:   if (per_zero) state_d = bus.Enable ? S_TRIG : S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        trig_d   = (state_q == S_TRIG);
        valid    = (state_q == S_DONE);
        latch    = (state_d == S_DONE) && (state_q != S_DONE);
        res_tout = !((state_q == S_MEASURE) && fall_q);
        res      = res_tout ? 8'hFF : cm_q;
    end

    // one down-counter serves the trigger width and then the echo timeout
    always_comb begin
        trig_entry = (state_d == S_TRIG) && (state_q != S_TRIG);
        tmr_d = tmr_q;
        per_d = per_q;
        sub_d = sub_q;
        cm_d  = cm_q;
        if (trig_entry)
            tmr_d = TW'(TRIG_CYCLES - 1);
        else if ((state_q == S_TRIG) && (state_d == S_WAIT_RISE))
            tmr_d = TW'(TIMEOUT_CYCLES - 1);
        else if (!tmr_zero)
            tmr_d = tmr_q - TW'(1);
        if (trig_entry)
            per_d = PW'(PERIOD_CYCLES - 1);
        else if (!per_zero)
            per_d = per_q - PW'(1);
        // the cycle that detects the rising edge already counts as echo-high
        if ((state_q == S_WAIT_RISE) && (state_d == S_MEASURE)) begin
            sub_d = SW'(1);
            cm_d  = '0;
        end else if (state_q == S_MEASURE) begin
            if (sub_q == SW'(CYCLES_PER_CM - 1)) begin
                sub_d = '0;
                if (cm_q != 8'hFF) cm_d = cm_q + 8'd1;
            end else begin
                sub_d = sub_q + SW'(1);
            end
        end
    end

    assign tout_d = latch ? res_tout : tout_q;

`ifdef RANGER_AVG4_EN
    logic [3:0][7:0] hist_q, hist_d;
    logic            primed_q, primed_d;
    logic [9:0]      sum_p2;

    always_comb begin
        hist_d   = hist_q;
        primed_d = primed_q;
        if (latch) begin
            primed_d = 1'b1;
            if (!primed_q) hist_d = {4{res}};
            else           hist_d = {hist_q[2:0], res};
        end
        sum_p2 = 10'd2 + {2'b00, hist_d[0]} + {2'b00, hist_d[1]}
                       + {2'b00, hist_d[2]} + {2'b00, hist_d[3]};
        dist_d = latch ? sum_p2[9:2] : dist_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hist_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            primed_q <= primed_d;
        end
    end
`else
    assign dist_d = latch ? res : dist_q;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            echo_s1_q  <= 1'b0;
            echo_s2_q  <= 1'b0;
            echo_dly_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            tmr_q      <= '0;
            per_q      <= '0;
            sub_q      <= '0;
            cm_q       <= '0;
            dist_q     <= 8'hFF;
            tout_q     <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            echo_s1_q  <= bus.Echo;
            echo_s2_q  <= echo_s1_q;
            echo_dly_q <= echo_s2_q;
            rise_q     <= echo_s2_q & ~echo_dly_q;
            fall_q     <= ~echo_s2_q & echo_dly_q;
            tmr_q      <= tmr_d;
            per_q      <= per_d;
            sub_q      <= sub_d;
            cm_q       <= cm_d;
            dist_q     <= dist_d;
            tout_q     <= tout_d;
            trig_q     <= trig_d;
        end
    end

    assign bus.Trig     = trig_q;
    assign bus.Distance = dist_q;
    assign bus.Valid    = valid;
    assign bus.Timeout  = tout_q;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger with a behavioural distance/averaging model.
module tb_ultrasonic_ranger;
    localparam int TRIG   = 4;
    localparam int CPC    = 10;
    localparam int TOUT   = 3000;
    localparam int PERIOD = 6000;

    logic clk;
    logic rst_n;
    ultrasonic_ranger_if bus();

    ultrasonic_ranger #(
        .TRIG_CYCLES(TRIG), .CYCLES_PER_CM(CPC),
        .TIMEOUT_CYCLES(TOUT), .PERIOD_CYCLES(PERIOD)
    ) dut (
        .CLK(clk),
        .RST(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0, trig_rises = 0, trig_falls = 0, valid_cnt = 0;
    int last_rise = 0, prev_rise = 0, last_fall = 0, last_valid = 0, last_width = 0;
    bit trig_prev = 1'b0;
    int hist[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.Trig === 1'b1 && !trig_prev) begin
            prev_rise = last_rise;
            last_rise = cyc;
            trig_rises++;
        end
        if (bus.Trig !== 1'b1 && trig_prev) begin
            last_fall  = cyc;
            last_width = cyc - last_rise;
            trig_falls++;
        end
        trig_prev = (bus.Trig === 1'b1);
        if (bus.Valid === 1'b1) begin
            valid_cnt++;
            last_valid = cyc;
        end
    end

    function automatic int raw_cm(input int n);
        return (n / CPC > 255) ? 255 : n / CPC;
    endfunction

    function automatic int model_push(input int raw);
`ifdef RANGER_AVG4_EN
        int s;
        if (hist.size() == 0) begin
            repeat (4) hist.push_back(raw);
        end else begin
            hist.push_back(raw);
            void'(hist.pop_front());
        end
        s = 0;
        foreach (hist[i]) s += hist[i];
        return (s + 2) / 4;
`else
        return raw;
`endif
    endfunction

    task automatic wait_rise(output bit ok);
        int r0;
        r0 = trig_rises;
        ok = 1'b0;
        for (int i = 0; i < PERIOD + 200; i++) begin
            @(negedge clk);
            if (trig_rises != r0) begin ok = 1'b1; break; end
        end
    endtask

    // waits for the next Trig fall, drives an echo of n cycles after dly cycles, waits for Valid
    task automatic run_measure(input int n, input int dly, input bit drop_en, output bit ok);
        int f0, v0;
        f0 = trig_falls;
        ok = 1'b0;
        for (int i = 0; i < PERIOD + 200; i++) begin
            @(negedge clk);
            if (trig_falls != f0) break;
        end
        if (trig_falls == f0) return;
        if (drop_en) bus.Enable = 1'b0;
        repeat (dly) @(negedge clk);
        v0 = valid_cnt;
        if (n > 0) begin
            bus.Echo = 1'b1;
            repeat (n) @(negedge clk);
            bus.Echo = 1'b0;
        end
        for (int i = 0; i < TOUT + 100; i++) begin
            if (valid_cnt != v0) break;
            @(negedge clk);
        end
        ok = (valid_cnt != v0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.Enable = 1'b0;
        bus.Echo = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.Trig !== 1'b0) begin n_err++; $display("FAIL reset_trig: got %b expected 0", bus.Trig); end
        n_cmp++; if (bus.Distance !== 8'hFF) begin n_err++; $display("FAIL reset_dist: got %0d expected 255", bus.Distance); end
        n_cmp++; if (bus.Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus.Valid); end
        n_cmp++; if (bus.Timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b expected 0", bus.Timeout); end
        bus.Enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first();
        bit ok;
        int vc, e;
        wait_rise(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL first_trig: got none expected rise"); end
        vc = valid_cnt;
        run_measure(125, 3, 1'b0, ok);
        e = model_push(raw_cm(125));
        n_cmp++; if (last_width != TRIG) begin n_err++; $display("FAIL trig_width: got %0d expected %0d", last_width, TRIG); end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL first_valid: got none expected pulse"); end
        n_cmp++; if (bus.Distance !== 8'(e)) begin n_err++; $display("FAIL first_dist: got %0d expected %0d", bus.Distance, e); end
        n_cmp++; if (bus.Timeout !== 1'b0) begin n_err++; $display("FAIL first_timeout: got %b expected 0", bus.Timeout); end
        repeat (3) @(negedge clk);
        n_cmp++; if (valid_cnt - vc != 1) begin n_err++; $display("FAIL first_valid_count: got %0d expected 1", valid_cnt - vc); end
    endtask

    task automatic test_saturate();
        bit ok;
        int e;
        run_measure(2700, 2, 1'b0, ok);
        e = model_push(raw_cm(2700));
        n_cmp++; if (!ok) begin n_err++; $display("FAIL sat_valid: got none expected pulse"); end
        n_cmp++; if (bus.Distance !== 8'(e)) begin n_err++; $display("FAIL sat_dist: got %0d expected %0d", bus.Distance, e); end
        n_cmp++; if (bus.Timeout !== 1'b0) begin n_err++; $display("FAIL sat_timeout: got %b expected 0", bus.Timeout); end
        n_cmp++; if (last_rise - prev_rise != PERIOD) begin n_err++; $display("FAIL sat_period: got %0d expected %0d", last_rise - prev_rise, PERIOD); end
    endtask

    task automatic test_random();
        bit ok;
        int n, d, e, vc;
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(2900, 15);
            d = $urandom_range(20, 1);
            vc = valid_cnt;
            run_measure(n, d, 1'b0, ok);
            e = model_push(raw_cm(n));
            repeat (3) @(negedge clk);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL rand_valid: n=%0d got none expected pulse", n); end
            n_cmp++; if (bus.Distance !== 8'(e)) begin n_err++; $display("FAIL rand_dist: n=%0d got %0d expected %0d", n, bus.Distance, e); end
            n_cmp++; if (bus.Timeout !== 1'b0) begin n_err++; $display("FAIL rand_timeout: n=%0d got %b expected 0", n, bus.Timeout); end
            n_cmp++; if (valid_cnt - vc != 1) begin n_err++; $display("FAIL rand_valid_count: got %0d expected 1", valid_cnt - vc); end
        end
    endtask

    task automatic test_no_echo();
        bit ok;
        int e, vc, el;
        vc = valid_cnt;
        run_measure(0, 0, 1'b0, ok);
        e = model_push(255);
        el = last_valid - last_fall;
        n_cmp++; if (!ok) begin n_err++; $display("FAIL noecho_valid: got none expected pulse"); end
        n_cmp++; if (bus.Distance !== 8'(e)) begin n_err++; $display("FAIL noecho_dist: got %0d expected %0d", bus.Distance, e); end
        n_cmp++; if (bus.Timeout !== 1'b1) begin n_err++; $display("FAIL noecho_timeout: got %b expected 1", bus.Timeout); end
        n_cmp++; if (el < TOUT - 5 || el > TOUT + 5) begin n_err++; $display("FAIL noecho_latency: got %0d expected %0d+-5", el, TOUT); end
        wait_rise(ok);
        n_cmp++; if (valid_cnt - vc != 1) begin n_err++; $display("FAIL noecho_valid_count: got %0d expected 1", valid_cnt - vc); end
        n_cmp++; if (!ok || last_rise - prev_rise != PERIOD) begin n_err++; $display("FAIL noecho_period: got %0d expected %0d", last_rise - prev_rise, PERIOD); end
    endtask

    task automatic test_long_echo();
        bit ok;
        int e, vc;
        vc = valid_cnt;
        run_measure(3500, 2, 1'b0, ok);
        e = model_push(255);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL long_valid: got none expected pulse"); end
        n_cmp++; if (bus.Distance !== 8'(e)) begin n_err++; $display("FAIL long_dist: got %0d expected %0d", bus.Distance, e); end
        n_cmp++; if (bus.Timeout !== 1'b1) begin n_err++; $display("FAIL long_timeout: got %b expected 1", bus.Timeout); end
        wait_rise(ok);
        n_cmp++; if (valid_cnt - vc != 1) begin n_err++; $display("FAIL long_valid_count: got %0d expected 1", valid_cnt - vc); end
        n_cmp++; if (!ok || last_rise - prev_rise != PERIOD) begin n_err++; $display("FAIL long_period: got %0d expected %0d", last_rise - prev_rise, PERIOD); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int e, r0;
        run_measure(333, 4, 1'b1, ok);
        e = model_push(raw_cm(333));
        n_cmp++; if (!ok) begin n_err++; $display("FAIL drop_valid: got none expected pulse"); end
        n_cmp++; if (bus.Distance !== 8'(e)) begin n_err++; $display("FAIL drop_dist: got %0d expected %0d", bus.Distance, e); end
        r0 = trig_rises;
        repeat (PERIOD + 100) @(negedge clk);
        n_cmp++; if (trig_rises != r0) begin n_err++; $display("FAIL drop_idle: got %0d trig rises expected 0", trig_rises - r0); end
        bus.Enable = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++; if (trig_rises - r0 != 1) begin n_err++; $display("FAIL drop_resume: got %0d trig rises expected 1", trig_rises - r0); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int f0;
        f0 = trig_falls;
        for (int i = 0; i < PERIOD + 200; i++) begin
            @(negedge clk);
            if (trig_falls != f0) break;
        end
        repeat (3) @(negedge clk);
        bus.Echo = 1'b1;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.Trig !== 1'b0) begin n_err++; $display("FAIL rstmid_trig: got %b expected 0", bus.Trig); end
        n_cmp++; if (bus.Distance !== 8'hFF) begin n_err++; $display("FAIL rstmid_dist: got %0d expected 255", bus.Distance); end
        n_cmp++; if (bus.Valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", bus.Valid); end
        n_cmp++; if (bus.Timeout !== 1'b0) begin n_err++; $display("FAIL rstmid_timeout: got %b expected 0", bus.Timeout); end
        bus.Echo = 1'b0;
        hist.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_rise(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_restart: got none expected trig rise"); end
    endtask

    task automatic test_avg_seq();
        bit ok;
        int widths[4];
        int exp_tab[4];
        widths = '{105, 205, 305, 405};
`ifdef RANGER_AVG4_EN
        exp_tab = '{10, 13, 18, 25};
`else
        exp_tab = '{10, 20, 30, 40};
`endif
        for (int k = 0; k < 4; k++) begin
            run_measure(widths[k], 2, 1'b0, ok);
            void'(model_push(raw_cm(widths[k])));
            n_cmp++; if (!ok) begin n_err++; $display("FAIL seq_valid: step %0d got none expected pulse", k); end
            n_cmp++; if (bus.Distance !== 8'(exp_tab[k])) begin n_err++; $display("FAIL seq_dist: step %0d got %0d expected %0d", k, bus.Distance, exp_tab[k]); end
        end
    endtask

    initial begin
        #(120000 * 10);
        $display("FAIL watchdog: got no finish expected completion within budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first();
        test_saturate();
        test_random();
        test_no_echo();
        test_long_echo();
        test_enable_drop();
        test_reset_mid();
        test_avg_seq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
